seven_segment_counter: RTL

Parametrised multi-digit BCD counter with a seven-segment display driver for the board's segment displays. It takes three raw push-button inputs (up, down, clear) and debounces each one internally. The count steps on each debounced press, wraps at a configurable maximum, and drives one seven-segment pattern per digit. It is the general replacement for single-digit, increment-only press counters in top-level designs.

---
 rtl/seven_segment_counter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_counter.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_counter
// Brief    : Debounced up/down/clear BCD counter with per-digit 7-seg driver.
//            Optional leading-zero blanking: SEVEN_SEGMENT_COUNTER_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_counter #(
  parameter int DIGITS         = 2,
  parameter int MAX_COUNT      = 99,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Switch_Up,
  input  logic                  i_Switch_Down,
  input  logic                  i_Switch_Clear,
  output logic [4*DIGITS-1:0]   o_Count,
  output logic [7*DIGITS-1:0]   o_Segments,
  output logic                  o_Wrap
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int c_CW    = 4 * DIGITS;
  localparam int c_SW    = 7 * DIGITS;
  localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(DEBOUNCE_LIMIT);
  localparam logic [c_SW-1:0]    c_SEG_MASK = (ACTIVE_LOW_SEG != 0) ? '1 : '0;

  function automatic logic [c_CW-1:0] to_bcd(input int value);
    int              v;
    logic [c_CW-1:0] b;
    v = value;
    b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  localparam logic [c_CW-1:0] c_MAX_BCD = to_bcd(MAX_COUNT);

  // Active-high glyphs, bit 0 = segment A ... bit 6 = segment G
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Switch index: 0 = up, 1 = down, 2 = clear
  logic [2:0]         w_raw;
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_stable;
  logic [2:0]         r_prev;
  logic [2:0]         w_press;
  logic [c_CNT_W-1:0] r_db_cnt [3];

  assign w_raw = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};

  // Stable value flips on the cycle the mismatch run would reach the limit
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_prev   <= '0;
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_stable;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] + c_CNT_W'(1) == c_LIMIT) begin
          r_stable[k] <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + c_CNT_W'(1);
        end
      end
    end
  end

  assign w_press = r_stable & ~r_prev;

  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_inc;
  logic [c_CW-1:0] w_dec;
  logic            r_wrap;

  always_comb begin : p_bcd_step
    logic carry;
    logic borrow;
    w_inc  = r_count;
    w_dec  = r_count;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (r_count[4*k +: 4] == 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_press[2]) begin
        r_count <= '0;
      end else if (w_press[0] && !w_press[1]) begin
        if (r_count == c_MAX_BCD) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= w_inc;
        end
      end else if (w_press[1] && !w_press[0]) begin
        if (r_count == '0) begin
          r_count <= c_MAX_BCD;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= w_dec;
        end
      end
    end
  end

  logic [c_SW-1:0] w_seg;
  logic [c_SW-1:0] w_seg_rst;
  logic [c_SW-1:0] r_seg;

  always_comb begin : p_seg_encode
`ifdef SEVEN_SEGMENT_COUNTER_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    w_seg     = '0;
    w_seg_rst = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_seg[7*k +: 7]     = glyph(r_count[4*k +: 4]);
      w_seg_rst[7*k +: 7] = glyph(4'd0);
`ifdef SEVEN_SEGMENT_COUNTER_BLANK_EN
      // Blank while every digit from the top down to here is zero
      if (k > 0 && lead && r_count[4*k +: 4] == 4'd0) begin
        w_seg[7*k +: 7] = 7'b0000000;
      end else begin
        lead = 1'b0;
      end
      if (k > 0) w_seg_rst[7*k +: 7] = 7'b0000000;
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_seg <= w_seg_rst ^ c_SEG_MASK;
    end else begin
      r_seg <= w_seg ^ c_SEG_MASK;
    end
  end

  assign o_Count    = r_count;
  assign o_Wrap     = r_wrap;
  assign o_Segments = r_seg;

endmodule
`default_nettype wire
